// File: rtl/pixel_writer_pkg.sv
// rtl/pixel_writer_pkg.sv - shared types, widths and address helper for pixel_writer
package pixel_writer_pkg;

    localparam int SCREEN_W_DEF = 160;
    localparam int SCREEN_H_DEF = 120;
    localparam int ADDR_W       = 15;
    localparam int COLOUR_W     = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    // Row-major address y*width + x as a constant shift-add: one term per set
    // bit of width (160 -> y<<7 + y<<5), so no multiplier is inferred.
    function automatic logic [ADDR_W-1:0] pixel_addr(input logic [6:0] y,
                                                     input logic [7:0] x,
                                                     input int unsigned width);
        logic [ADDR_W-1:0] acc;
        acc = {7'd0, x};
        for (int i = 0; i < 9; i++) begin
            if (width[i]) begin
                acc = acc + ({8'd0, y} << i);
            end
        end
        return acc;
    endfunction

endpackage

// File: rtl/pixel_fifo.sv
// rtl/pixel_fifo.sv - synchronous plot-request FIFO with registered count
// Ports: clk/rst (async active-low); push/push_data write side;
//        pop, head_data (oldest entry), next_data (entry behind head);
//        full, empty, count status.
module pixel_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 18
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_data,
    output logic [WIDTH-1:0]           next_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A push against a full FIFO is refused even if a pop frees a slot this cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);
    assign head_data = mem[rd_ptr];
    assign next_data = mem[rd_ptr + PTR_W'(1)];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/pixel_writer.sv
// rtl/pixel_writer.sv - buffers pixel plots and screen clears into framebuffer writes
// Ports: clk, rst (async active-low); plot/x_coord/y_coord/colour plot request;
//        clear/clear_colour fill request; ready (plot will be stored);
//        fb_addr/fb_data/fb_we/fb_ready framebuffer write handshake;
//        busy, overflow (sticky), dropped (saturating off-screen count).
module pixel_writer
    import pixel_writer_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int SCREEN_W   = SCREEN_W_DEF,
    parameter int SCREEN_H   = SCREEN_H_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                plot,
    input  logic [7:0]          x_coord,
    input  logic [6:0]          y_coord,
    input  logic [COLOUR_W-1:0] colour,
    input  logic                clear,
    input  logic [COLOUR_W-1:0] clear_colour,
    output logic                ready,
    output logic [ADDR_W-1:0]   fb_addr,
    output logic [COLOUR_W-1:0] fb_data,
    output logic                fb_we,
    input  logic                fb_ready,
    output logic                busy,
    output logic                overflow,
    output logic [7:0]          dropped
);

    localparam int ENTRY_W = ADDR_W + COLOUR_W;
    localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam logic [8:0]        W_LIM     = 9'(SCREEN_W);
    localparam logic [7:0]        H_LIM     = 8'(SCREEN_H);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SCREEN_W * SCREEN_H - 1);

    state_t               state, state_n;
    logic                 pending, pending_n;
    logic [COLOUR_W-1:0]  clr_colour, clr_colour_n;
    logic                 fb_we_n;
    logic [ADDR_W-1:0]    fb_addr_n;
    logic [COLOUR_W-1:0]  fb_data_n;
    logic                 busy_n;

    logic                 on_screen;
    logic                 push_ok;
    logic                 pop;
    logic [ADDR_W-1:0]    plot_addr;
    logic [ENTRY_W-1:0]   head_data;
    logic [ENTRY_W-1:0]   next_data;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [CNT_W-1:0]     fifo_count;
    logic [CNT_W-1:0]     count_n;

    assign on_screen = ({1'b0, x_coord} < W_LIM) && ({1'b0, y_coord} < H_LIM);
    assign ready     = !fifo_full && (state != ST_CLEAR) && !pending;
    assign push_ok   = plot && on_screen && ready;
    assign plot_addr = pixel_addr(y_coord, x_coord, SCREEN_W);

    pixel_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_ok),
        .push_data ({plot_addr, colour}),
        .pop       (pop),
        .head_data (head_data),
        .next_data (next_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // The FIFO head stays in the FIFO while it is being offered on the
    // framebuffer port; it is popped only on the accepted handshake, so the
    // buffer holds exactly FIFO_DEPTH requests under back-pressure.
    always_comb begin
        state_n      = state;
        fb_we_n      = fb_we;
        fb_addr_n    = fb_addr;
        fb_data_n    = fb_data;
        pending_n    = pending;
        clr_colour_n = clr_colour;
        pop          = 1'b0;

        if (clear && !pending && (state != ST_CLEAR)) begin
            pending_n    = 1'b1;
            clr_colour_n = clear_colour;
        end

        case (state)
            ST_IDLE: begin
                // New plots are blocked while a clear is pending, so the FIFO
                // only has to drain once before the fill may start.
                if (pending && fifo_empty) begin
                    state_n   = ST_CLEAR;
                    fb_we_n   = 1'b1;
                    fb_addr_n = '0;
                    fb_data_n = clr_colour;
                end else if (!fifo_empty) begin
                    state_n = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!fb_we) begin
                    if (!fifo_empty) begin
                        fb_we_n   = 1'b1;
                        fb_addr_n = head_data[ENTRY_W-1:COLOUR_W];
                        fb_data_n = head_data[COLOUR_W-1:0];
                    end else begin
                        state_n = ST_IDLE;
                    end
                end else if (fb_ready) begin
                    pop = 1'b1;
                    if (fifo_count > CNT_W'(1)) begin
                        fb_addr_n = next_data[ENTRY_W-1:COLOUR_W];
                        fb_data_n = next_data[COLOUR_W-1:0];
                    end else begin
                        // Last buffered entry retired; a plot landing this same
                        // cycle is picked up from the head on the next cycle.
                        fb_we_n = 1'b0;
                        state_n = push_ok ? ST_DRAIN : ST_IDLE;
                    end
                end
            end
            ST_CLEAR: begin
                if (fb_ready) begin
                    if (fb_addr == LAST_ADDR) begin
                        fb_we_n   = 1'b0;
                        state_n   = ST_IDLE;
                        pending_n = 1'b0;
                    end else begin
                        fb_addr_n = fb_addr + ADDR_W'(1);
                    end
                end
            end
            default: begin
                state_n = ST_IDLE;
                fb_we_n = 1'b0;
            end
        endcase

        count_n = fifo_count + CNT_W'(push_ok) - CNT_W'(pop);
        busy_n  = (state_n != ST_IDLE) || (count_n != '0) || pending_n;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fb_we      <= 1'b0;
            fb_addr    <= '0;
            fb_data    <= '0;
            pending    <= 1'b0;
            clr_colour <= '0;
            busy       <= 1'b0;
            overflow   <= 1'b0;
            dropped    <= '0;
        end else begin
            fb_we      <= fb_we_n;
            fb_addr    <= fb_addr_n;
            fb_data    <= fb_data_n;
            pending    <= pending_n;
            clr_colour <= clr_colour_n;
            busy       <= busy_n;
            if (plot && on_screen && !ready) begin
                overflow <= 1'b1;
            end
            if (plot && !on_screen && (dropped != 8'hFF)) begin
                dropped <= dropped + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_pixel_writer.sv
// tb/tb_pixel_writer.sv - self-checking scoreboard bench for pixel_writer
module tb_pixel_writer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        plot = 1'b0;
    logic [7:0]  x_coord = '0;
    logic [6:0]  y_coord = '0;
    logic [2:0]  colour = '0;
    logic        clear = 1'b0;
    logic [2:0]  clear_colour = '0;
    logic        ready;
    logic [14:0] fb_addr;
    logic [2:0]  fb_data;
    logic        fb_we;
    logic        fb_ready = 1'b0;
    logic        busy;
    logic        overflow;
    logic [7:0]  dropped;

    int checks = 0;
    int failures = 0;
    logic [17:0] sb [$];

    logic        hold_valid = 1'b0;
    logic [14:0] hold_addr;
    logic [2:0]  hold_data;

    pixel_writer dut (
        .clk          (clk),
        .rst          (rst),
        .plot         (plot),
        .x_coord      (x_coord),
        .y_coord      (y_coord),
        .colour       (colour),
        .clear        (clear),
        .clear_colour (clear_colour),
        .ready        (ready),
        .fb_addr      (fb_addr),
        .fb_data      (fb_data),
        .fb_we        (fb_we),
        .fb_ready     (fb_ready),
        .busy         (busy),
        .overflow     (overflow),
        .dropped      (dropped)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Framebuffer monitor: every accepted write must match the scoreboard head,
    // and a stalled write must hold its address and data.
    always @(negedge clk) begin
        if (!rst) begin
            hold_valid = 1'b0;
        end else begin
            if (hold_valid) begin
                chk("stall_hold", {fb_we, fb_addr, fb_data}, {1'b1, hold_addr, hold_data});
            end
            hold_valid = fb_we && !fb_ready;
            hold_addr  = fb_addr;
            hold_data  = fb_data;
            if (fb_we && fb_ready) begin
                checks++;
                assert (sb.size() > 0) else begin
                    failures++;
                    $error("FAIL unexpected_write observed=addr %0d data %0d expected=no write",
                           fb_addr, fb_data);
                end
                if (sb.size() > 0) begin
                    logic [17:0] e;
                    e = sb.pop_front();
                    chk("write_addr", fb_addr, e[17:3]);
                    chk("write_data", fb_data, e[2:0]);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic plot_px(input int x, input int y, input int c, input bit stored);
        plot    = 1'b1;
        x_coord = 8'(x);
        y_coord = 7'(y);
        colour  = 3'(c);
        if (stored) sb.push_back({15'(y * 160 + x), 3'(c)});
        step();
        plot = 1'b0;
    endtask

    task automatic wait_drain(input int limit, input bit stutter);
        for (int i = 0; i < limit && sb.size() != 0; i++) begin
            if (stutter) fb_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        fb_ready = 1'b1;
        chk("scoreboard_drained", sb.size(), 0);
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_fb_we", fb_we, 0);
        chk("rst_fb_addr", fb_addr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_dropped", dropped, 0);
        step();
        rst = 1'b1;
        chk("rst_ready", ready, 1);

        // Single plot latency: accept at edge N, write visible after edge N+2
        fb_ready = 1'b1;
        plot_px(5, 3, 2, 1'b1);
        chk("lat_busy", busy, 1);
        chk("lat_we_n0", fb_we, 0);
        step();
        chk("lat_we_n1", fb_we, 0);
        step();
        chk("lat_we_n2", fb_we, 1);
        chk("lat_addr", fb_addr, 485);
        chk("lat_data", fb_data, 2);
        step();
        chk("lat_we_done", fb_we, 0);
        wait_drain(20, 1'b0);

        // Back-pressure: 8 stored, 9th overflows
        fb_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (i == 8) chk("full_ready", ready, 0);
            plot_px(10 + i, 2 * i, i, i < 8);
        end
        chk("overflow_set", overflow, 1);
        chk("full_ready_after", ready, 0);
        step();
        chk("stall_we", fb_we, 1);
        fb_ready = 1'b1;
        wait_drain(60, 1'b0);
        step();
        chk("drain_busy", busy, 0);
        chk("overflow_sticky", overflow, 1);

        // Off-screen plots
        plot_px(160, 0, 1, 1'b0);
        plot_px(0, 120, 1, 1'b0);
        chk("dropped_two", dropped, 2);
        step();
        chk("offscreen_no_we", fb_we, 0);
        for (int i = 0; i < 300; i++) plot_px(200 + (i % 50), i % 128, 3, 1'b0);
        chk("dropped_sat", dropped, 255);
        plot_px(159, 119, 6, 1'b1);
        wait_drain(20, 1'b0);

        // Clear with 3 plots queued, random back-pressure during the fill
        fb_ready = 1'b0;
        plot_px(1, 1, 1, 1'b1);
        plot_px(2, 2, 3, 1'b1);
        plot_px(3, 3, 5, 1'b1);
        clear        = 1'b1;
        clear_colour = 3'd7;
        step();
        clear        = 1'b0;
        clear_colour = 3'd2;
        clear        = 1'b1;   // duplicate while pending: ignored
        step();
        clear = 1'b0;
        chk("clear_ready", ready, 0);
        chk("clear_busy", busy, 1);
        for (int a = 0; a < 19200; a++) sb.push_back({15'(a), 3'd7});
        wait_drain(40000, 1'b1);
        chk("clear_busy_fall", busy, 0);
        chk("clear_we_fall", fb_we, 0);
        chk("clear_ready_back", ready, 1);

        // Reset in the middle of a clear
        clear        = 1'b1;
        clear_colour = 3'd5;
        step();
        clear = 1'b0;
        for (int a = 0; a <= 1100; a++) sb.push_back({15'(a), 3'd5});
        for (int i = 0; i < 3000 && !(fb_we && fb_addr == 15'd1000); i++) step();
        chk("clear_at_1000", fb_addr, 1000);
        #1;
        rst = 1'b0;
        #1;
        chk("mid_rst_we", fb_we, 0);
        chk("mid_rst_addr", fb_addr, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_overflow", overflow, 0);
        chk("mid_rst_dropped", dropped, 0);
        sb.delete();
        step();
        rst = 1'b1;
        for (int i = 0; i < 40; i++) step();
        chk("post_rst_we", fb_we, 0);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_ready", ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pixel_writer.md
PIXEL_WRITER -- requirements
Module: pixel_writer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, plot-request buffer depth (power of 2).
REQ-002 SHALL have parameter SCREEN_W, default 160, visible width in pixels.
REQ-003 SHALL have parameter SCREEN_H, default 120, visible height in pixels.
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 plot  in  1  one-cycle pixel request strobe from a drawing engine.
REQ-007 x_coord  in  8  pixel column.
REQ-008 y_coord  in  7  pixel row.
REQ-009 colour  in  3  pixel colour.
REQ-010 clear  in  1  one-cycle request to fill the whole screen.
REQ-011 clear_colour  in  3  fill colour, sampled with clear.
REQ-012 ready  out  1  high when a plot this cycle will be stored.
REQ-013 fb_addr  out  15  framebuffer word address.
REQ-014 fb_data  out  3  framebuffer write data.
REQ-015 fb_we  out  1  framebuffer write request.
REQ-016 fb_ready  in  1  framebuffer accepts the write this cycle.
REQ-017 busy  out  1  high in DRAIN or CLEAR, or while FIFO non-empty or clear pending.
REQ-018 overflow  out  1  sticky; a plot arrived while ready was low.
REQ-019 dropped  out  8  saturating count of off-screen plots discarded.

Function
REQ-020 Plot accepted when plot=1, ready=1 and x_coord<SCREEN_W and y_coord<SCREEN_H; {address, colour} pushed to FIFO.
REQ-021 Off-screen plot SHALL not be pushed; dropped increments, saturating at 255; overflow unaffected.
REQ-022 Address = y*SCREEN_W + x, computed at push time; 160x120 max 19199 fits 15 bits; no multiplier (shift-add: y<<7 + y<<5 + x).
REQ-023 ready = FIFO not full AND state != CLEAR AND no clear pending.
REQ-024 On-screen plot with ready=0 SHALL be discarded and set overflow; overflow clears only on reset.
REQ-025 Push when full rejected even if a pop occurs in the same cycle; push and pop on a non-full, non-empty FIFO in one cycle SHALL both succeed.
REQ-026 States IDLE, DRAIN, CLEAR.
REQ-027 IDLE: clear pending -> CLEAR (priority); else FIFO non-empty -> DRAIN.
REQ-028 DRAIN: fb_we=1 with fb_addr/fb_data from FIFO head; on fb_we&&fb_ready pop and load next entry; FIFO empty after pop -> IDLE.
REQ-029 fb_addr/fb_data SHALL stay stable while fb_we=1 and fb_ready=0.
REQ-030 Latency: plot accepted at edge N into empty FIFO in IDLE -> fb_we=1 with its address after edge N+2.
REQ-031 clear SHALL latch a pending flag and clear_colour in any state; duplicate clear while pending or in CLEAR ignored.
REQ-032 Pending clear SHALL wait until FIFO empty and current write done, then CLEAR starts.
REQ-033 CLEAR: write addresses 0..SCREEN_W*SCREEN_H-1 ascending with latched colour, one per accepted handshake; after last accepted write -> IDLE, pending cleared.
REQ-034 fb_we SHALL be 0 in IDLE.
REQ-035 All outputs registered except ready.

Reset
REQ-036 rst low SHALL immediately force state IDLE, fb_we=0, fb_addr=0, fb_data=0, overflow=0, dropped=0, FIFO empty, clear pending 0, busy=0; ready=1 after release.
REQ-037 Reset mid-DRAIN or mid-CLEAR abandons the operation; no resume after release.

Structure
REQ-038 Shared package holds state enum, SCREEN_W/SCREEN_H defaults, address width 15, colour width 3.
REQ-039 FIFO SHALL be sub-module pixel_fifo (synchronous, registered count, full/empty flags).

Verification
REQ-040 plot x=5,y=3,colour=2, fb_ready=1 -> one write addr 485 data 2, fb_we 2 cycles after accept.
REQ-041 fb_ready=0 for 10 cycles, 9 plots on consecutive cycles -> first 8 stored, 9th sets overflow, ready=0; then fb_ready=1 -> 8 writes in order.
REQ-042 plot x=160,y=0 and x=0,y=120 -> no write, dropped=2; 300 off-screen plots -> dropped=255.
REQ-043 clear colour=7 with 3 plots queued -> 3 plot writes, then 19200 writes addr 0..19199 data 7, busy falls after last.
REQ-044 rst low during CLEAR at addr 1000 -> fb_we=0 same cycle; after release no writes, ready=1.
